// File: rtl/peak_track_if.sv
// Stream bundle for peak_track: framed per-bin sink beats in, per-peak source beats out.
interface peak_track_if #(
  parameter int NCHAN = 3,
  parameter int WIDTH = 25
);
  logic                        sink_valid;
  logic                        sink_sop;
  logic                        sink_eop;
  logic [WIDTH-1:0]            sink_mag;
  logic [0:NCHAN-1][15:0]      sink_phase;
  logic                        source_valid;
  logic                        source_sop;
  logic                        source_eop;
  logic [23:0]                 source_freq;
  logic [WIDTH-1:0]            source_mag;
  logic [0:NCHAN-1][15:0]      source_phase;
  logic                        error;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
    input  source_valid, source_sop, source_eop, source_freq, source_mag, source_phase, error
  );
  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_mag, sink_phase,
    output source_valid, source_sop, source_eop, source_freq, source_mag, source_phase, error
  );
endinterface

// File: rtl/peak_track.sv
// Multi-channel spectral peak tracker: keeps the NPEAKS strongest positive-frequency bins per frame.
// Define PEAK_TRACK_LOCALMAX_EN to restrict candidates to local maxima (one peak per lobe).
module peak_track #(
  parameter int NCHAN  = 3,
  parameter int WIDTH  = 25,
  parameter int FFT    = 11,
  parameter int NPEAKS = 4,
  parameter int BINHZ  = 10000
) (
  input logic       clk,
  input logic       reset,
  peak_track_if.slave bus
);
  localparam int IW = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;

  typedef struct packed {
    logic [WIDTH-1:0]       mag;
    logic [FFT-1:0]         bin;
    logic [0:NCHAN-1][15:0] ph;
  } ent_t;

  typedef enum logic {IDLE, EMIT} st_t;

  st_t                    state_q, state_d;
  logic                   active_q, active_d;
  logic [FFT-1:0]         bin_q, bin_d;
  ent_t                   win_q [0:1];
  ent_t                   win_d [0:1];
  logic                   shift_q, shift_d;
`ifdef PEAK_TRACK_LOCALMAX_EN
  logic [WIDTH-1:0]       win2_mag_q, win2_mag_d;
`endif
  ent_t                   tab_q [NPEAKS];
  ent_t                   tab_d [NPEAKS];
  ent_t                   ins   [NPEAKS];
  ent_t                   buf_q [NPEAKS];
  ent_t                   buf_d [NPEAKS];
  logic [IW-1:0]          idx_q, idx_d;
  logic                   error_q, error_d;

  logic                   src_valid_q, src_valid_d;
  logic                   src_sop_q, src_sop_d;
  logic                   src_eop_q, src_eop_d;
  logic [23:0]            src_freq_q, src_freq_d;
  logic [WIDTH-1:0]       src_mag_q, src_mag_d;
  logic [0:NCHAN-1][15:0] src_ph_q, src_ph_d;

  logic                   acc, sop_acc, eop_acc, cand_ok;
  logic [FFT-1:0]         cur_bin;
  logic [NPEAKS-1:0]      gt;
  ent_t                   cand, e;

  assign acc     = bus.sink_valid & (bus.sink_sop | active_q);
  assign sop_acc = bus.sink_valid & bus.sink_sop;
  assign eop_acc = acc & bus.sink_eop;
  assign cur_bin = bus.sink_sop ? '0 : bin_q + 1'b1;

  // Window: win_q[0] newest beat, win_q[1] the bin under test.
  always_comb begin
    active_d = active_q;
    bin_d    = bin_q;
    win_d    = win_q;
    shift_d  = 1'b0;
`ifdef PEAK_TRACK_LOCALMAX_EN
    win2_mag_d = win2_mag_q;
`endif
    if (acc) begin
      active_d = ~bus.sink_eop;
      bin_d    = cur_bin;
      shift_d  = 1'b1;
      win_d[0] = '{mag: bus.sink_mag, bin: cur_bin, ph: bus.sink_phase};
      win_d[1] = bus.sink_sop ? '0 : win_q[0];
`ifdef PEAK_TRACK_LOCALMAX_EN
      win2_mag_d = bus.sink_sop ? '0 : win_q[1].mag;
`endif
    end
  end

  always_comb begin
    cand    = win_q[1];
    cand_ok = shift_q && (cand.bin != '0) && !cand.bin[FFT-1] && (cand.mag != '0)
`ifdef PEAK_TRACK_LOCALMAX_EN
              && (cand.mag > win2_mag_q) && (cand.mag >= win_q[0].mag)
`endif
              ;
  end

  // Table is sorted descending, so gt[] is a thermometer; its first set bit is the slot.
  always_comb begin
    for (int i = 0; i < NPEAKS; i++) gt[i] = cand_ok && (cand.mag > tab_q[i].mag);
    ins[0] = gt[0] ? cand : tab_q[0];
    for (int i = 1; i < NPEAKS; i++)
      ins[i] = gt[i] ? (gt[i-1] ? tab_q[i-1] : cand) : tab_q[i];
    for (int i = 0; i < NPEAKS; i++) begin
      tab_d[i] = sop_acc ? '0 : ins[i];
      buf_d[i] = (state_q == IDLE && eop_acc) ? tab_d[i] : buf_q[i];
    end
    error_d = error_q | (eop_acc && state_q == EMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = '0;
    case (state_q)
      IDLE: if (eop_acc) state_d = EMIT;
      EMIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NPEAKS - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    e           = buf_q[idx_q];
    src_valid_d = 1'b0;
    src_sop_d   = 1'b0;
    src_eop_d   = 1'b0;
    src_freq_d  = '0;
    src_mag_d   = '0;
    src_ph_d    = '0;
    if (state_q == EMIT) begin
      src_valid_d = 1'b1;
      src_sop_d   = (idx_q == '0);
      src_eop_d   = (idx_q == IW'(NPEAKS - 1));
      src_freq_d  = 24'(32'(e.bin) * 32'(BINHZ));
      src_mag_d   = e.mag;
      src_ph_d[0] = e.ph[0];
      // Plain 16-bit subtraction wraps naturally modulo 2*pi.
      for (int c = 1; c < NCHAN; c++) src_ph_d[c] = e.ph[c] - e.ph[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q    <= 1'b0;
      bin_q       <= '0;
      win_q[0]    <= '0;
      win_q[1]    <= '0;
      shift_q     <= 1'b0;
`ifdef PEAK_TRACK_LOCALMAX_EN
      win2_mag_q  <= '0;
`endif
      for (int i = 0; i < NPEAKS; i++) begin
        tab_q[i] <= '0;
        buf_q[i] <= '0;
      end
      idx_q       <= '0;
      error_q     <= 1'b0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_freq_q  <= '0;
      src_mag_q   <= '0;
      src_ph_q    <= '0;
    end else begin
      active_q    <= active_d;
      bin_q       <= bin_d;
      win_q       <= win_d;
      shift_q     <= shift_d;
`ifdef PEAK_TRACK_LOCALMAX_EN
      win2_mag_q  <= win2_mag_d;
`endif
      tab_q       <= tab_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      error_q     <= error_d;
      src_valid_q <= src_valid_d;
      src_sop_q   <= src_sop_d;
      src_eop_q   <= src_eop_d;
      src_freq_q  <= src_freq_d;
      src_mag_q   <= src_mag_d;
      src_ph_q    <= src_ph_d;
    end
  end

  assign bus.source_valid = src_valid_q;
  assign bus.source_sop   = src_sop_q;
  assign bus.source_eop   = src_eop_q;
  assign bus.source_freq  = src_freq_q;
  assign bus.source_mag   = src_mag_q;
  assign bus.source_phase = src_ph_q;
  assign bus.error        = error_q;

endmodule

// File: doc/peak_track.md
# peak_track

Multi-channel spectral peak tracker that sits after the cartesian-to-polar stage of the phase-extraction pipeline. It takes the framed per-bin magnitude/phase stream (one reference magnitude plus NCHAN phases per beat) and keeps the NPEAKS strongest positive-frequency bins per frame in a sorted table. At end of frame it emits one beat per peak with frequency, magnitude, absolute reference phase and wrapped inter-channel phase differences. It generalises the fixed 3-antenna, fixed-peak output stage to any channel count, peak count and bin spacing, and adds overflow detection.

## Interface
- NCHAN, 3, number of antenna channels (≥2)
- WIDTH, 25, magnitude width, UQ<WIDTH>.0
- FFT, 11, log2 of frame length (≥3)
- NPEAKS, 4, table depth and beats emitted per frame (≥1)
- BINHZ, 10000, Hz per bin
- clk  in  1  main clock
- reset  in  1  asynchronous reset, active-high
- sink_valid  in  1  input beat valid
- sink_sop  in  1  first beat of frame (bin 0)
- sink_eop  in  1  last beat of frame
- sink_mag  in  WIDTH  reference-channel magnitude, UQ<WIDTH>.0
- sink_phase[0:NCHAN-1]  in  16 each  per-channel phase, Q1.15 (pi rad)
- source_valid  out  1  output beat valid
- source_sop  out  1  first peak beat
- source_eop  out  1  last peak beat
- source_freq  out  24  bin × BINHZ, UQ24.0
- source_mag  out  WIDTH  peak magnitude
- source_phase[0:NCHAN-1]  out  16 each  index 0 absolute; index c>0 = phase[c] − phase[0], Q1.15
- error  out  1  sticky overflow flag

## Operation
- Beats count only when sink_valid=1. sink_sop beat sets bin=0 and frame-active; each later valid beat increments bin. Beats outside an active frame are ignored. sop while active restarts the frame (table cleared, no output). eop while inactive is ignored. eop clears frame-active.
- Candidate window: 3-beat shift register of (mag, phases, bin). Middle entry k is a candidate when 1 ≤ k ≤ 2^(FFT-1)−1, mag > 0, and qualified per Configuration. Bin 0 and bins ≥ 2^(FFT-1) are never candidates.
- Table: NPEAKS entries sorted descending by mag, cleared to mag=0, bin=0, phases=0 at sop. Candidate inserts at the lowest index i with mag > entry[i].mag (strict: earlier bin wins ties); entries i..NPEAKS-2 shift down, last dropped. One insertion per cycle.
- Phase difference: 16-bit two's-complement subtraction, natural wrap (mod 2π).
- FSM IDLE/EMIT. Accepted eop in IDLE: table copied to output buffer, IDLE→EMIT. EMIT sends entries 0..NPEAKS-1, one per cycle, then returns to IDLE. Unused entries emit freq=0, mag=0, phases=0. Accumulation of the next frame continues during EMIT.
- eop accepted while in EMIT: frame dropped, error←1 until reset. No backpressure.
- source_freq = bin × BINHZ truncated to 24 bits, registered.

## Timing
- eop accepted at edge N → beats registered at edges N+1..N+NPEAKS. source_sop is high with beat 0, source_eop with beat NPEAKS−1, and with beat 0 when NPEAKS=1. Minimum frame-to-frame eop spacing is NPEAKS+1 cycles.
- Last candidate (bin 2^(FFT-1)−1) is inserted well before eop for FFT≥3.
- Reset: all outputs 0, error=0, FSM IDLE, table and window cleared, frame inactive. Assertion mid-frame or mid-EMIT aborts immediately with no partial output after deassertion.

## Configuration
- PEAK_TRACK_LOCALMAX_EN defined: a candidate also requires mag[k] > mag[k−1] and mag[k] ≥ mag[k+1], so each lobe yields one peak.
- Undefined: every in-range bin with mag > 0 is a candidate, so a broad lobe can fill several slots.

## Test plan
- Defaults, 2048-beat frame, mags 0 except bins 100/300/500/700/900 = 5000/4000/3000/2000/1000 → 4 beats, freq 1000000, 3000000, 5000000, 7000000; sop on beat 0, eop on beat 3, first beat one edge after eop.
- Bin 100 with phase0=0x7000, phase1=0x9000, phase2=0x7000 → source_phase = {0x7000, 0x2000, 0x0000}.
- Bins 99/100/101 = 4000/5000/4500. With macro → single peak at freq 1000000, other beats zero. Without macro → freqs 1000000, 1010000, 990000.
- Bin 0 = 9000, bin 1500 = 9000, bins 200 and 400 = 3000 → beats freq 2000000 then 4000000, then two zero beats.
- Second eop arrives 2 cycles after the first → second frame dropped, error=1 and held. Reset asserted mid-frame → all outputs 0 and error=0 immediately, and no beats follow the interrupted frame's eop.
